rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 3-to-8 decoded resource (e.g. eight enable lines) among eight requesters.
- Selects a winner, registers its 3-bit index, and drives the matching one-hot grant (index decoded to 8 lines).
- Holds the grant until release, then advances fairness.
- Sits between requesting units and the decoder-driven select lines.

Parameters:
- MAX_HOLD, 4, maximum consecutive grant cycles before forced release (only with ARB_TIMEOUT_EN); legal range 1..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit k = requester k.
- done  input  1  current grant holder releases the resource this cycle.
- grant  output  8  one-hot grant, all-zero when idle; always equals the decode of grant_idx when grant_valid=1.
- grant_idx  output  3  index of current winner.
- grant_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, grant=8'h00, grant_idx=3'd0, grant_valid=0, timeout=0, ptr=3'd0, hold_cnt=0.
- Reset mid-grant: grant drops immediately (asynchronous).
- State machine, two states:
  - IDLE:
    - If req==0, stay in IDLE.
    - Else pick the first set bit scanning ptr, ptr+1, ... ptr+7 (mod 8).
    - Register winner: grant_idx=w, grant=1<<w, grant_valid=1, hold_cnt=1; go to GRANT.
  - GRANT:
    - Release when any of: done=1; req[grant_idx]=0; or (ARB_TIMEOUT_EN and hold_cnt==MAX_HOLD).
    - On release, next cycle: grant=0, grant_valid=0, ptr=grant_idx+1 (3-bit wrap, 7→0); go to IDLE.
    - Otherwise hold_cnt++ (saturating) and grant stays stable.
- Latency:
  - req rising in cycle N while IDLE → grant_valid=1 at edge N+1.
  - Release condition in cycle M → grant=0 after edge M+1.
  - Exactly one idle gap cycle between consecutive grants; next winner is granted at edge M+2.
- Simultaneous events:
  - done and timeout condition in the same cycle: treated as a normal release; timeout not pulsed.
  - New requests arriving during GRANT do not preempt the holder.
- Fairness:
  - A requester holding req continuously is granted within 8 arbitrations.
  - The last winner has lowest priority in the next arbitration.
- Only one grant bit is ever set.
- req[k] dropping while k is not granted has no effect.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt compares against MAX_HOLD and forces release.
  - timeout pulses 1 for one cycle, aligned with grant falling to 0.
- Undefined:
  - No hold counter logic; grant held until done or req drop.
  - timeout tied 0.

Test Plan:
- Reset: rst_n=0 with req=8'hFF → grant=00, grant_idx=0, grant_valid=0. Release reset, hold req=8'h01 → grant=01, grant_idx=0 one cycle later.
- Rotation: req=8'hFF held, done pulsed one cycle in every grant → grant order 01,02,04,...,80,01 (wrap 7→0), one idle cycle between each.
- Priority pointer: after idx 5 served, req=8'h21 → grant=01 (idx 0), since bit 5 has lowest priority.
- Request drop: grant=04, deassert req[2] → grant=00 next cycle; ptr=3.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=8'h08 held, done=0 → grant=08 for exactly 4 cycles, timeout=1 for one cycle as grant falls, regrant to 08 after the idle cycle. Undefined macro → grant=08 held indefinitely, timeout stays 0.
- Async reset mid-grant: grant=10, assert rst_n=0 between edges → grant=00 immediately; after release, req=8'h10 → regranted with ptr=0.

Source files
------------

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// slave  : arbiter side (consumes req/done, produces grant signals)
// master : requester side
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with registered index and one-hot grant.
// Optional macro ARB_TIMEOUT_EN: forced release after MAX_HOLD consecutive
// grant cycles, flagged by a one-cycle timeout pulse. Without the macro there
// is no hold counter and timeout is tied low.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_arbiter8_if.slave    bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q;
  logic [7:0] grant_q;
  logic [2:0] idx_q;
  logic       valid_q;
  logic [2:0] ptr_q;

  logic [2:0] win_d;
  logic       found_d;
  logic [2:0] cand;
  logic       rel_norm;

  // First requester at or after ptr (mod 8); scan from the far end down so the
  // lowest offset wins the last assignment.
  always_comb begin
    win_d   = ptr_q;
    found_d = 1'b0;
    cand    = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr_q + 3'(i);
      if (bus.req[cand]) begin
        win_d   = cand;
        found_d = 1'b1;
      end
    end
  end

  // Holder gives up the resource, or stops asking for it.
  assign rel_norm = bus.done | ~bus.req[idx_q];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q;
  logic       timeout_q;
  logic       rel_to;

  // Forced release only counts as a timeout when no normal release coincides.
  assign rel_to = (hold_q == 8'(MAX_HOLD)) & ~rel_norm;

  // Arbiter FSM with hold counter; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 8'h00;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      ptr_q     <= 3'd0;
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            idx_q   <= win_d;
            grant_q <= 8'h01 << win_d;
            valid_q <= 1'b1;
            hold_q  <= 8'd1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (rel_norm || rel_to) begin
            grant_q   <= 8'h00;
            valid_q   <= 1'b0;
            ptr_q     <= idx_q + 3'd1;
            hold_q    <= 8'd0;
            timeout_q <= rel_to;
            state_q   <= IDLE;
          end else if (hold_q != 8'hFF) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.timeout = timeout_q;
`else
  // Arbiter FSM; grant held until done or request drop. Outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 8'h00;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      ptr_q   <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            idx_q   <= win_d;
            grant_q <= 8'h01 << win_d;
            valid_q <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (rel_norm) begin
            grant_q <= 8'h00;
            valid_q <= 1'b0;
            ptr_q   <= idx_q + 3'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.timeout = 1'b0;
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, rotation, pointer priority, request
// drop, hold behaviour (with/without ARB_TIMEOUT_EN) and async reset mid-grant.
module tb_rr_arbiter8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle before sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req  = 8'hFF;
    bus.done = 1'b0;

    // reset with all requesting
    step(); step();
    chk("rst_grant", bus.grant, 8'h00);
    chk("rst_idx", {5'd0, bus.grant_idx}, 8'h00);
    chk("rst_valid", {7'd0, bus.grant_valid}, 8'h00);
    chk("rst_timeout", {7'd0, bus.timeout}, 8'h00);

    bus.req = 8'h01;
    rst_n   = 1'b1;
    step();
    chk("first_grant", bus.grant, 8'h01);
    chk("first_idx", {5'd0, bus.grant_idx}, 8'h00);
    chk("first_valid", {7'd0, bus.grant_valid}, 8'h01);

    // rotation with done pulsed once per grant, one idle cycle between
    bus.req = 8'hFF;
    for (int i = 1; i <= 8; i++) begin
      bus.done = 1'b1;
      step();
      chk("rot_gap", bus.grant, 8'h00);
      bus.done = 1'b0;
      step();
      chk("rot_grant", bus.grant, 8'h01 << (i % 8));
    end

    // serve idx 5, then bit 5 has lowest priority against bit 0
    bus.req  = 8'h20;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    chk("ptr_grant5", bus.grant, 8'h20);
    bus.req  = 8'h21;
    bus.done = 1'b1;
    step();
    chk("ptr_gap", bus.grant, 8'h00);
    bus.done = 1'b0;
    step();
    chk("ptr_grant0", bus.grant, 8'h01);

    // request drop releases; ptr becomes 3
    bus.req  = 8'h04;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    chk("drop_grant", bus.grant, 8'h04);
    bus.req = 8'h00;
    step();
    chk("drop_release", bus.grant, 8'h00);
    chk("drop_valid", {7'd0, bus.grant_valid}, 8'h00);
    bus.req = 8'h0C;
    step();
    chk("drop_ptr3", bus.grant, 8'h08);
    chk("drop_idx3", {5'd0, bus.grant_idx}, 8'h03);

    // hold with done low (grant 08 visible since the last edge)
    bus.req = 8'h08;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_hold", bus.grant, 8'h08);
      chk("to_quiet", {7'd0, bus.timeout}, 8'h00);
    end
    step();
    chk("to_release", bus.grant, 8'h00);
    chk("to_pulse", {7'd0, bus.timeout}, 8'h01);
    step();
    chk("to_regrant", bus.grant, 8'h08);
    chk("to_pulse_end", {7'd0, bus.timeout}, 8'h00);
`else
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_grant", bus.grant, 8'h08);
      chk("hold_timeout", {7'd0, bus.timeout}, 8'h00);
    end
`endif

    // async reset mid-grant
    bus.req  = 8'h10;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    chk("ar_grant", bus.grant, 8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_drop", bus.grant, 8'h00);
    chk("ar_valid", {7'd0, bus.grant_valid}, 8'h00);
    // ptr back at 0: bit 0 beats bit 4
    bus.req = 8'h11;
    #1;
    rst_n = 1'b1;
    step();
    chk("ar_ptr0", bus.grant, 8'h01);
    bus.req  = 8'h10;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    chk("ar_regrant", bus.grant, 8'h10);
    chk("ar_idx", {5'd0, bus.grant_idx}, 8'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
